// File: rtl/contador_de1_po.sv
// Ones-counter datapath: shift register A, saturating counter B, sticky
// illegal-command flag. Ports: clk, reset (async, active-low), entrada,
// LoadA/ShiftR/IncB/RstB commands in; zeroA/zeroA0/saidaB/erro out.
module contador_de1_po #(
  parameter int N  = 8,
  parameter int BW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  entrada,
  input  logic          LoadA,
  input  logic          ShiftR,
  input  logic          IncB,
  input  logic          RstB,
  output logic          zeroA,
  output logic          zeroA0,
  output logic [BW-1:0] saidaB,
  output logic          erro
);

  logic [N-1:0]  r_a;
  logic [BW-1:0] r_b;
  logic          r_erro;

  logic [N-1:0]  w_a_shr;
  logic          w_b_full;
  logic          w_illegal;

  // Logical shift; for N=1 this yields 0 as well.
  assign w_a_shr   = r_a >> 1;
  assign w_b_full  = (r_b == BW'(N));
  assign w_illegal = (LoadA & ShiftR) | (RstB & IncB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
    end else if (LoadA) begin
      r_a <= entrada;
    end else if (ShiftR) begin
      r_a <= w_a_shr;
    end
  end

  // B saturates at N so an extra increment never wraps the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_b <= '0;
    end else if (RstB) begin
      r_b <= '0;
    end else if (IncB && !w_b_full) begin
      r_b <= r_b + BW'(1);
    end
  end

  // Sticky: only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_erro <= 1'b0;
    end else if (w_illegal) begin
      r_erro <= 1'b1;
    end
  end

  assign zeroA  = (r_a == '0);
  assign zeroA0 = r_a[0];
  assign saidaB = r_b;
  assign erro   = r_erro;

endmodule
